// File: rtl/hazard_pkg.sv
// hazard_pkg: shared constants and types for the hazard/forwarding unit.
//   FWD_* : EX operand mux select encodings.
//   stage_t : destination metadata carried down the shadow pipeline.
package hazard_pkg;

    localparam int REG_ADDR_W = 5;

    localparam logic [1:0] FWD_REGFILE = 2'b00;
    localparam logic [1:0] FWD_MEMWB   = 2'b01;
    localparam logic [1:0] FWD_EXMEM   = 2'b10;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic                  reg_write;
        logic                  mem_read;
        logic                  valid;
    } stage_t;

endpackage

// File: rtl/fwd_select.sv
// fwd_select: per-operand forwarding priority compare (purely combinational).
//   ex_valid              : EX holds a real instruction
//   rs                    : EX source register for this operand
//   mem_valid/reg_write/rd: EX/MEM producer metadata
//   wb_valid/reg_write/rd : MEM/WB producer metadata
//   sel                   : operand mux select (FWD_* encoding)
module fwd_select
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W = hazard_pkg::REG_ADDR_W
) (
    input  logic                  ex_valid,
    input  logic [REG_ADDR_W-1:0] rs,
    input  logic                  mem_valid,
    input  logic                  mem_reg_write,
    input  logic [REG_ADDR_W-1:0] mem_rd,
    input  logic                  wb_valid,
    input  logic                  wb_reg_write,
    input  logic [REG_ADDR_W-1:0] wb_rd,
    output logic [1:0]            sel
);

    logic mem_hit;
    logic wb_hit;

    // x0 is hardwired zero, so a write to it never produces a value to forward.
    assign mem_hit = mem_valid && mem_reg_write && (mem_rd != '0) && (mem_rd == rs);
    assign wb_hit  = wb_valid  && wb_reg_write  && (wb_rd  != '0) && (wb_rd  == rs);

    always_comb begin
        sel = FWD_REGFILE;
        if (ex_valid) begin
            // The younger producer (EX/MEM) holds the newest value, so it wins.
            if (mem_hit)     sel = FWD_EXMEM;
            else if (wb_hit) sel = FWD_MEMWB;
        end
    end

endmodule

// File: rtl/hazard_forward_unit.sv
// hazard_forward_unit: EX operand forwarding selects plus load-use stall and
// branch flush controls for a 5-stage pipeline. Tracks its own shadow copy of
// destination metadata for ID/EX, EX/MEM and MEM/WB.
//   clk, reset            : rising-edge clock, async active-high reset
//   id_*                  : instruction currently in ID
//   ex_branch_taken       : branch/jump resolved taken in EX
//   fwd_a_sel, fwd_b_sel  : EX operand mux selects (00 regfile, 10 EX/MEM, 01 MEM/WB)
//   stall                 : load-use stall; pc_write/ifid_write are its inverse
//   flush                 : squash IF/ID and ID/EX
module hazard_forward_unit
    import hazard_pkg::*;
#(
    parameter int REG_ADDR_W         = hazard_pkg::REG_ADDR_W,
    parameter int NUM_STAGES_TRACKED = 3
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs1,
    input  logic [REG_ADDR_W-1:0] id_rs2,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_reg_write,
    input  logic                  id_mem_read,
    input  logic                  ex_branch_taken,
    output logic [1:0]            fwd_a_sel,
    output logic [1:0]            fwd_b_sel,
    output logic                  stall,
    output logic                  pc_write,
    output logic                  ifid_write,
    output logic                  flush
);

    localparam int NUM_OPS = 2;  // operand A, operand B

    // Shadow pipeline as a shift register: [0] ID/EX, [1] EX/MEM, [2] MEM/WB.
    stage_t [NUM_STAGES_TRACKED-1:0]      shd;
    logic   [NUM_OPS-1:0][REG_ADDR_W-1:0] ex_rs;
    logic   [NUM_OPS-1:0][1:0]            sel;
    stage_t                               ex_in;
    logic                                 load_use;
    logic                                 bubble;
    logic                                 unused_mem_read;

    // Only the ID/EX copy of mem_read matters; older copies ride along unused.
    assign unused_mem_read = shd[1].mem_read | shd[2].mem_read;

    assign load_use = shd[0].valid && shd[0].mem_read && (shd[0].rd != '0) && id_valid &&
                      ((shd[0].rd == id_rs1) || (shd[0].rd == id_rs2));

    // Flush dominates stall: the PC must be free to take the branch target.
    assign flush      = ex_branch_taken & ~reset;
    assign stall      = load_use & ~flush & ~reset;
    assign pc_write   = ~stall;
    assign ifid_write = ~stall;
    assign bubble     = stall | flush;

    always_comb begin
        ex_in           = '0;
        ex_in.rd        = id_rd;
        ex_in.reg_write = id_reg_write & ~bubble;
        ex_in.mem_read  = id_mem_read  & ~bubble;
        ex_in.valid     = id_valid     & ~bubble;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            shd   <= '0;
            ex_rs <= '0;
        end else begin
            shd   <= {shd[NUM_STAGES_TRACKED-2:0], ex_in};
            ex_rs <= {id_rs2, id_rs1};
        end
    end

    for (genvar i = 0; i < NUM_OPS; i++) begin : g_op
        fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_sel (
            .ex_valid      (shd[0].valid),
            .rs            (ex_rs[i]),
            .mem_valid     (shd[1].valid),
            .mem_reg_write (shd[1].reg_write),
            .mem_rd        (shd[1].rd),
            .wb_valid      (shd[2].valid),
            .wb_reg_write  (shd[2].reg_write),
            .wb_rd         (shd[2].rd),
            .sel           (sel[i])
        );
    end

    assign fwd_a_sel = sel[0];
    assign fwd_b_sel = sel[1];

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs1, id_rs2, id_rd;
    logic       id_reg_write, id_mem_read, ex_branch_taken;
    logic [1:0] fwd_a_sel, fwd_b_sel;
    logic       stall, pc_write, ifid_write, flush;

    int tests_run    = 0;
    int tests_failed = 0;

    // Observed vector: {fwd_a, fwd_b, stall, pc_write, ifid_write, flush}
    wire [7:0] obs = {fwd_a_sel, fwd_b_sel, stall, pc_write, ifid_write, flush};

    hazard_forward_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_rd(id_rd), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
        .ex_branch_taken(ex_branch_taken), .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall(stall), .pc_write(pc_write), .ifid_write(ifid_write), .flush(flush)
    );

    always #5 clk = ~clk;

    // ---------------- stimulus helpers ----------------
    task automatic set_id(input bit v, input int rs1, input int rs2, input int rd,
                          input bit rw, input bit mr);
        id_valid     = v;
        id_rs1       = 5'(rs1);
        id_rs2       = 5'(rs2);
        id_rd        = 5'(rd);
        id_reg_write = rw;
        id_mem_read  = mr;
    endtask

    task automatic idle();
        set_id(0, 0, 0, 0, 0, 0);
        ex_branch_taken = 0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        idle();
        reset = 1;
        tick();
        reset = 0;
    endtask

    // ---------------- directed tests ----------------
    task automatic test_reset();
        logic [7:0] exp;
        reset = 1;
        set_id(1, 3, 3, 3, 1, 1);
        ex_branch_taken = 1;
        @(negedge clk);
        exp = 8'b00_00_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_state: got %b expected %b", obs, exp);
        end
        tick();
        do_reset();
    endtask

    task automatic test_raw_prev();
        logic [7:0] exp;
        do_reset();
        set_id(1, 1, 2, 5, 1, 0);          // add x5
        tick();
        set_id(1, 5, 3, 9, 1, 0);          // sub x9, x5, x3
        @(negedge clk);
        exp = 8'b00_00_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL raw_prev_producer_in_ex: got %b expected %b", obs, exp);
        end
        tick();
        idle();
        @(negedge clk);
        exp = 8'b10_00_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL raw_prev: got %b expected %b", obs, exp);
        end
        tick();
    endtask

    task automatic test_two_back();
        logic [7:0] exp;
        do_reset();
        set_id(1, 1, 2, 6, 1, 0);          // add x6
        tick();
        idle();                            // nop
        tick();
        set_id(1, 1, 6, 11, 1, 0);         // and x11, x1, x6
        tick();
        idle();
        @(negedge clk);
        exp = 8'b00_01_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL two_back: got %b expected %b", obs, exp);
        end
        tick();
    endtask

    task automatic test_double_match();
        logic [7:0] exp;
        do_reset();
        set_id(1, 1, 2, 7, 1, 0);
        tick();
        set_id(1, 3, 4, 7, 1, 0);
        tick();
        set_id(1, 7, 7, 12, 1, 0);
        tick();
        idle();
        @(negedge clk);
        exp = 8'b10_10_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL double_match: got %b expected %b", obs, exp);
        end
        tick();
    endtask

    task automatic test_x0();
        logic [7:0] exp;
        do_reset();
        set_id(1, 1, 2, 0, 1, 0);          // add x0
        tick();
        set_id(1, 0, 0, 0, 1, 1);          // ld x0, reads x0
        tick();
        set_id(1, 0, 0, 13, 1, 0);         // use x0 while ld x0 in EX
        @(negedge clk);
        exp = 8'b00_00_0110;               // no fwd, no stall on x0
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL x0_load_no_stall: got %b expected %b", obs, exp);
        end
        tick();
        idle();
        @(negedge clk);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL x0_no_forward: got %b expected %b", obs, exp);
        end
        tick();
    endtask

    task automatic test_load_use();
        logic [7:0] exp;
        do_reset();
        set_id(1, 1, 0, 8, 1, 1);          // ld x8
        tick();
        set_id(1, 3, 8, 10, 1, 0);         // consumer rs2 = x8
        @(negedge clk);
        exp = 8'b00_00_1000;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL load_use_stall: got %b expected %b", obs, exp);
        end
        tick();                            // ID held, bubble enters EX
        @(negedge clk);
        exp = 8'b00_00_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL load_use_one_bubble: got %b expected %b", obs, exp);
        end
        tick();
        idle();
        @(negedge clk);
        exp = 8'b00_01_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL load_use_forward: got %b expected %b", obs, exp);
        end
        tick();
    endtask

    task automatic test_back_to_back_loads();
        logic [7:0] exp;
        do_reset();
        set_id(1, 1, 0, 8, 1, 1);          // ld x8
        tick();
        set_id(1, 8, 0, 9, 1, 1);          // ld x9, 0(x8)
        @(negedge clk);
        exp = 8'b00_00_1000;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL b2b_first_stall: got %b expected %b", obs, exp);
        end
        tick();
        @(negedge clk);
        exp = 8'b00_00_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL b2b_first_release: got %b expected %b", obs, exp);
        end
        tick();                            // ld x9 in EX, x8 in WB
        set_id(1, 9, 2, 14, 1, 0);
        @(negedge clk);
        exp = 8'b01_00_1000;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL b2b_second_stall: got %b expected %b", obs, exp);
        end
        tick();
        @(negedge clk);
        exp = 8'b00_00_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL b2b_second_release: got %b expected %b", obs, exp);
        end
        tick();
        idle();
    endtask

    task automatic test_flush_stall();
        logic [7:0] exp;
        do_reset();
        set_id(1, 1, 0, 8, 1, 1);          // ld x8
        tick();
        set_id(1, 3, 8, 10, 1, 0);
        ex_branch_taken = 1;
        @(negedge clk);
        exp = 8'b00_00_0111;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL flush_beats_stall: got %b expected %b", obs, exp);
        end
        tick();
        idle();
        @(negedge clk);                    // squashed consumer would show fwd_b = 10
        exp = 8'b00_00_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL flush_bubble: got %b expected %b", obs, exp);
        end
        tick();
    endtask

    task automatic test_reset_mid_stall();
        logic [7:0] exp;
        do_reset();
        set_id(1, 1, 0, 8, 1, 1);
        tick();
        set_id(1, 3, 8, 10, 1, 0);
        @(negedge clk);
        exp = 8'b00_00_1000;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL mid_stall_setup: got %b expected %b", obs, exp);
        end
        #1 reset = 1;
        ex_branch_taken = 1;
        #1;
        exp = 8'b00_00_0110;
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL reset_mid_stall: got %b expected %b", obs, exp);
        end
        #1 reset = 0;
        ex_branch_taken = 0;
        tick();
        idle();
        @(negedge clk);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL no_pending_bubble: got %b expected %b", obs, exp);
        end
        tick();
    endtask

    // ---------------- randomized test with reference model ----------------
    typedef struct {
        bit v, rw, mr;
        int rd, rs1, rs2;
    } ins_t;

    // Instruction history entering EX, oldest first: [0] WB, [1] MEM, [2] EX.
    ins_t hist[$];

    function automatic logic [1:0] model_fwd(input int rs);
        if (!hist[2].v) return 2'b00;
        for (int age = 1; age <= 2; age++) begin
            ins_t p = hist[2-age];
            if (p.v && p.rw && p.rd != 0 && p.rd == rs) return (age == 1) ? 2'b10 : 2'b01;
        end
        return 2'b00;
    endfunction

    task automatic test_random();
        ins_t cur, bub, ex;
        bit held = 0, br, exp_stall;
        logic [7:0] exp;
        bub = '{v:0, rw:0, mr:0, rd:0, rs1:0, rs2:0};
        cur = bub;
        do_reset();
        hist = {bub, bub, bub};
        for (int cyc = 0; cyc < 400; cyc++) begin
            if (!held) begin
                cur.v   = ($urandom % 4) != 0;
                cur.rs1 = $urandom % 8;
                cur.rs2 = $urandom % 8;
                cur.rd  = $urandom % 8;
                cur.rw  = ($urandom % 4) != 0;
                cur.mr  = ($urandom % 3) == 0;
            end
            br = ($urandom % 8) == 0;
            set_id(cur.v, cur.rs1, cur.rs2, cur.rd, cur.rw, cur.mr);
            ex_branch_taken = br;
            ex = hist[2];
            exp_stall = ex.v && ex.mr && ex.rd != 0 && cur.v &&
                        (ex.rd == cur.rs1 || ex.rd == cur.rs2) && !br;
            exp = {model_fwd(ex.rs1), model_fwd(ex.rs2), exp_stall, !exp_stall, !exp_stall, br};
            @(negedge clk);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL random cycle %0d: got %b expected %b", cyc, obs, exp);
            end
            tick();
            hist.push_back((exp_stall || br) ? bub : cur);
            void'(hist.pop_front());
            held = exp_stall;
        end
        idle();
    endtask

    initial begin
        reset = 1;
        idle();
        test_reset();
        test_raw_prev();
        test_two_back();
        test_double_match();
        test_x0();
        test_load_use();
        test_back_to_back_loads();
        test_flush_stall();
        test_reset_mid_stall();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
